// File: rtl/fp2_addsub_pipe.sv
// Fully pipelined Fp2 modular adder/subtractor, one limb per stage plus a final select stage.
// Optional operand range check enabled by defining FP2_ADDSUB_RANGE_CHK_EN.
module fp2_addsub_pipe #(
    parameter int unsigned  W     = 255,
    parameter int unsigned  LIMB  = 64,
    parameter logic [W-1:0] P     = W'((256'd5 << 248) - 256'd1),
    parameter int unsigned  TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [W-1:0]     a_re,
    input  logic [W-1:0]     a_im,
    input  logic [W-1:0]     b_re,
    input  logic [W-1:0]     b_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     d_re,
    output logic [W-1:0]     d_im,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam int unsigned NL      = (W + LIMB - 1) / LIMB;
    localparam int unsigned LATENCY = NL + 1;
    localparam int unsigned NSTG    = LATENCY - 1;
    localparam int unsigned LAST    = NSTG - 1;
    localparam int unsigned LW_LAST = W - (NL - 1) * LIMB;
    localparam logic [LIMB-1:0] LAST_MASK = LIMB'({LW_LAST{1'b1}});
    localparam logic [W-1:0]    LMASK     = W'({LIMB{1'b1}});

    // x holds {A upper limbs, r lower limbs}; y holds {B upper limbs, r2 lower limbs}.
    logic             v_q    [NSTG];
    logic             v_d    [NSTG];
    logic             mode_q [NSTG];
    logic             mode_d [NSTG];
    logic [TAG_W-1:0] tag_q  [NSTG];
    logic [TAG_W-1:0] tag_d  [NSTG];
    logic [W-1:0]     re_x_q [NSTG];
    logic [W-1:0]     re_x_d [NSTG];
    logic [W-1:0]     re_y_q [NSTG];
    logic [W-1:0]     re_y_d [NSTG];
    logic [W-1:0]     im_x_q [NSTG];
    logic [W-1:0]     im_x_d [NSTG];
    logic [W-1:0]     im_y_q [NSTG];
    logic [W-1:0]     im_y_d [NSTG];
    logic             re_c1_q[NSTG];
    logic             re_c1_d[NSTG];
    logic             re_c2_q[NSTG];
    logic             re_c2_d[NSTG];
    logic             im_c1_q[NSTG];
    logic             im_c1_d[NSTG];
    logic             im_c2_q[NSTG];
    logic             im_c2_d[NSTG];

    logic             out_valid_q;
    logic [W-1:0]     d_re_q, d_re_d;
    logic [W-1:0]     d_im_q, d_im_d;
    logic [TAG_W-1:0] out_tag_q;
    logic             stall;

    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = out_valid_q;
    assign d_re      = d_re_q;
    assign d_im      = d_im_q;
    assign out_tag   = out_tag_q;

    // Carries/borrows are taken at bit lw, so the narrow top limb never spills past bit W.
    function automatic void limb_step(
        input  logic [W-1:0] x_i,
        input  logic [W-1:0] y_i,
        input  logic         c1_i,
        input  logic         c2_i,
        input  logic         add_i,
        input  int unsigned  j,
        output logic [W-1:0] x_o,
        output logic [W-1:0] y_o,
        output logic         c1_o,
        output logic         c2_o
    );
        int unsigned     sh, lw;
        logic [LIMB-1:0] lm, a_l, b_l, p_l, r_l, r2_l;
        logic [LIMB:0]   s1, s2;
        sh  = j * LIMB;
        lw  = (j == NL - 1) ? LW_LAST : LIMB;
        lm  = (j == NL - 1) ? LAST_MASK : '1;
        a_l = LIMB'(x_i >> sh);
        b_l = LIMB'(y_i >> sh);
        p_l = LIMB'(P >> sh);
        if (add_i) s1 = {1'b0, a_l} + {1'b0, b_l} + (LIMB+1)'(c1_i);
        else       s1 = {1'b0, a_l} - {1'b0, b_l} - (LIMB+1)'(c1_i);
        r_l = s1[LIMB-1:0] & lm;
        if (add_i) s2 = {1'b0, r_l} - {1'b0, p_l} - (LIMB+1)'(c2_i);
        else       s2 = {1'b0, r_l} + {1'b0, p_l} + (LIMB+1)'(c2_i);
        r2_l = s2[LIMB-1:0] & lm;
        c1_o = ((s1 >> lw) & (LIMB+1)'(1)) != '0;
        c2_o = ((s2 >> lw) & (LIMB+1)'(1)) != '0;
        x_o  = (x_i & ~(LMASK << sh)) | (W'(r_l) << sh);
        y_o  = (y_i & ~(LMASK << sh)) | (W'(r2_l) << sh);
    endfunction

    always_comb begin
        for (int unsigned j = 0; j < NSTG; j++) begin
            if (j == 0) begin
                v_d[j]    = in_valid;
                mode_d[j] = in_mode;
                tag_d[j]  = in_tag;
                limb_step(a_re, b_re, 1'b0, 1'b0, in_mode, j,
                          re_x_d[j], re_y_d[j], re_c1_d[j], re_c2_d[j]);
                limb_step(a_im, b_im, 1'b0, 1'b0, in_mode, j,
                          im_x_d[j], im_y_d[j], im_c1_d[j], im_c2_d[j]);
            end else begin
                v_d[j]    = v_q[j-1];
                mode_d[j] = mode_q[j-1];
                tag_d[j]  = tag_q[j-1];
                limb_step(re_x_q[j-1], re_y_q[j-1], re_c1_q[j-1], re_c2_q[j-1], mode_q[j-1], j,
                          re_x_d[j], re_y_d[j], re_c1_d[j], re_c2_d[j]);
                limb_step(im_x_q[j-1], im_y_q[j-1], im_c1_q[j-1], im_c2_q[j-1], mode_q[j-1], j,
                          im_x_d[j], im_y_d[j], im_c1_d[j], im_c2_d[j]);
            end
        end
    end

    // Sub: take r+P on borrow. Add: take r-P on carry-out or when r-P did not borrow.
    always_comb begin
        d_re_d = re_x_q[LAST];
        d_im_d = im_x_q[LAST];
        if (mode_q[LAST] ? (re_c1_q[LAST] || !re_c2_q[LAST]) : re_c1_q[LAST]) d_re_d = re_y_q[LAST];
        if (mode_q[LAST] ? (im_c1_q[LAST] || !im_c2_q[LAST]) : im_c1_q[LAST]) d_im_d = im_y_q[LAST];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned j = 0; j < NSTG; j++) v_q[j] <= 1'b0;
            out_valid_q <= 1'b0;
            d_re_q      <= '0;
            d_im_q      <= '0;
            out_tag_q   <= '0;
        end else if (!stall) begin
            v_q         <= v_d;
            out_valid_q <= v_q[LAST];
            d_re_q      <= d_re_d;
            d_im_q      <= d_im_d;
            out_tag_q   <= tag_q[LAST];
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            mode_q  <= mode_d;
            tag_q   <= tag_d;
            re_x_q  <= re_x_d;
            re_y_q  <= re_y_d;
            im_x_q  <= im_x_d;
            im_y_q  <= im_y_d;
            re_c1_q <= re_c1_d;
            re_c2_q <= re_c2_d;
            im_c1_q <= im_c1_d;
            im_c2_q <= im_c2_d;
        end
    end

`ifdef FP2_ADDSUB_RANGE_CHK_EN
    logic err_q [NSTG];
    logic err_d [NSTG];
    logic out_err_q;

    always_comb begin
        for (int unsigned j = 0; j < NSTG; j++) begin
            if (j == 0) err_d[j] = (a_re >= P) || (a_im >= P) || (b_re >= P) || (b_im >= P);
            else        err_d[j] = err_q[j-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned j = 0; j < NSTG; j++) err_q[j] <= 1'b0;
            out_err_q <= 1'b0;
        end else if (!stall) begin
            err_q     <= err_d;
            out_err_q <= err_q[LAST];
        end
    end

    assign out_err = out_err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_fp2_addsub_pipe.sv
// Self-checking bench for fp2_addsub_pipe: modular-arithmetic scoreboard plus directed literal checks.
module tb_fp2_addsub_pipe;

    localparam int unsigned  W     = 255;
    localparam int unsigned  TAG_W = 8;
    localparam logic [W-1:0] P     = W'((256'd5 << 248) - 256'd1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_mode = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [W-1:0]     a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     d_re, d_im;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    fp2_addsub_pipe #(.W(W), .LIMB(64), .P(P), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_tag(in_tag),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .d_re(d_re), .d_im(d_im), .out_tag(out_tag), .out_err(out_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    int pop_cnt = 0, pop_first = -1, pop_last = -1, stall_seen = 0, err_seen = 0;

    typedef struct {
        logic [W-1:0]     re;
        logic [W-1:0]     im;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] fp_op(input logic add, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        if (add) begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, P}) s = s - {1'b0, P};
        end else if (a >= b) s = {1'b0, a} - {1'b0, b};
        else                 s = {1'b0, a} + {1'b0, P} - {1'b0, b};
        return W'(s);
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [255:0] x;
        x = '0;
        for (int i = 0; i < 8; i++) x = {x[223:0], 32'($urandom())};
        return x[W-1:0] % P;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push at accept, pop and compare at output transfer, hold check during stall.
    logic             prev_stall = 1'b0;
    logic [W-1:0]     prev_re, prev_im;
    logic [TAG_W-1:0] prev_tag;
    logic             prev_err;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_valid", W'(out_valid), W'(1'b1));
                chk("stall_hold_re", d_re, prev_re);
                chk("stall_hold_im", d_im, prev_im);
                chk("stall_hold_tag", W'(out_tag), W'(prev_tag));
                chk("stall_hold_err", W'(out_err), W'(prev_err));
            end
            chk("in_ready_rule", W'(in_ready), W'(!(out_valid && !out_ready)));
            if (out_valid && !out_ready) stall_seen++;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL spurious_output: got tag %h expected no result", out_tag);
                end else begin
                    e = q.pop_front();
                    chk("out_tag", W'(out_tag), W'(e.tag));
                    chk("out_err", W'(out_err), W'(e.err));
                    if (!e.err) begin
                        chk("d_re", d_re, e.re);
                        chk("d_im", d_im, e.im);
                    end
                    if (out_err) err_seen++;
                    if (pop_first < 0) pop_first = cyc;
                    pop_last = cyc;
                    pop_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                e.re  = fp_op(in_mode, a_re, b_re);
                e.im  = fp_op(in_mode, a_im, b_im);
                e.tag = in_tag;
                e.err = 1'b0;
`ifdef FP2_ADDSUB_RANGE_CHK_EN
                e.err = (a_re >= P) || (a_im >= P) || (b_re >= P) || (b_im >= P);
`endif
                q.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            prev_re = d_re; prev_im = d_im; prev_tag = out_tag; prev_err = out_err;
        end
    end

    task automatic send(input logic m, input logic [W-1:0] ar, input logic [W-1:0] br,
                        input logic [W-1:0] ai, input logic [W-1:0] bi, input logic [TAG_W-1:0] tg);
        logic acc;
        acc = 1'b0;
        in_mode = m; a_re = ar; b_re = br; a_im = ai; b_im = bi; in_tag = tg; in_valid = 1'b1;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++; failures++;
            $display("FAIL send_timeout: got no accept for tag %h expected accept", tg);
        end
    endtask

    task automatic run_one(input logic m, input logic [W-1:0] ar, input logic [W-1:0] br,
                           input logic [W-1:0] ai, input logic [W-1:0] bi, input logic [TAG_W-1:0] tg,
                           output logic [W-1:0] rre, output logic [W-1:0] rim,
                           output logic [TAG_W-1:0] rtag, output int lat);
        in_mode = m; a_re = ar; b_re = br; a_im = ai; b_im = bi; in_tag = tg; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        rre = d_re; rim = d_im; rtag = out_tag;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain: got %0d results outstanding expected 0", q.size());
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "time limit expired");
    end

    initial begin : stim
        logic [W-1:0]     rre, rim;
        logic [TAG_W-1:0] rtag;
        int               lat, bad;

        chk("model_sub_wrap", fp_op(1'b0, W'(5), W'(7)), P - W'(2));
        chk("model_sub_plain", fp_op(1'b0, W'(7), W'(5)), W'(2));
        chk("model_add_reduce", fp_op(1'b1, P - W'(1), W'(2)), W'(1));
        chk("model_add_zero", fp_op(1'b1, P - W'(1), W'(1)), W'(0));

        repeat (3) @(negedge clk);
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_d_re", d_re, W'(0));
        chk("rst_d_im", d_im, W'(0));
        chk("rst_out_tag", W'(out_tag), W'(0));
        chk("rst_out_err", W'(out_err), W'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("rst_in_ready", W'(in_ready), W'(1));

        run_one(1'b0, W'(5), W'(7), W'(7), W'(5), 8'h11, rre, rim, rtag, lat);
        chk("sub_wrap_re", rre, P - W'(2));
        chk("sub_wrap_im", rim, W'(2));
        chk("sub_wrap_tag", W'(rtag), W'(8'h11));
        chk("sub_wrap_latency", W'(lat), W'(5));

        run_one(1'b1, P - W'(1), W'(2), W'(1), W'(2), 8'h22, rre, rim, rtag, lat);
        chk("add_reduce_re", rre, W'(1));
        chk("add_reduce_im", rim, W'(3));
        chk("add_reduce_latency", W'(lat), W'(5));

        run_one(1'b1, P - W'(1), W'(1), W'(0), W'(0), 8'h33, rre, rim, rtag, lat);
        chk("add_zero_re", rre, W'(0));
        chk("add_zero_im", rim, W'(0));

        pop_cnt = 0; pop_first = -1;
        for (int i = 0; i < 16; i++) send(1'(i), rnd(), rnd(), rnd(), rnd(), TAG_W'(i));
        drain();
        chk("stream_count", W'(pop_cnt), W'(16));
        chk("stream_span", W'(pop_last - pop_first), W'(15));

        stall_seen = 0; pop_cnt = 0;
        fork
            for (int i = 0; i < 10; i++) send(1'(i + 1), rnd(), rnd(), rnd(), rnd(), TAG_W'(8'h40 + i));
            begin
                repeat (7) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_stall_cycles", W'(stall_seen), W'(3));
        chk("bp_count", W'(pop_cnt), W'(10));

        for (int i = 0; i < 3; i++) send(1'(i), rnd(), rnd(), rnd(), rnd(), TAG_W'(8'h60 + i));
        repeat (3) @(posedge clk);
        #2 chk("pre_rst_valid", W'(out_valid), W'(1));
        rst = 1'b0;
        #1 chk("rst_async_valid", W'(out_valid), W'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("post_rst_quiet", W'(bad), W'(0));
        @(posedge clk);
        #1;
        run_one(1'b0, W'(9), W'(4), W'(3), W'(3), 8'h77, rre, rim, rtag, lat);
        chk("post_rst_latency", W'(lat), W'(5));
        chk("post_rst_re", rre, W'(5));
        chk("post_rst_im", rim, W'(0));

`ifdef FP2_ADDSUB_RANGE_CHK_EN
        err_seen = 0;
        send(1'b0, W'(10), W'(3), W'(4), W'(1), 8'h80);
        send(1'b1, W'(10), W'(3), W'(4), P, 8'h81);
        send(1'b1, W'(10), W'(3), W'(4), W'(1), 8'h82);
        drain();
        chk("range_err_count", W'(err_seen), W'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
